fft_frame_ctrl: RTL and testbench

FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

---
 rtl/fft_frame_ctrl.sv | 118 +++++++++++
 tb/tb_fft_frame_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_ctrl.sv
// rtl/fft_frame_ctrl.sv - frames an audio sample stream into FFT input frames and indexes FFT output bins
module fft_frame_ctrl #(
  parameter int FRAME_LEN = 1024,
  parameter int DATA_W    = 16,
  parameter int CNT_W     = $clog2(FRAME_LEN)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic              i_sample_valid,
  input  logic [DATA_W-1:0] i_sample,
  output logic              o_sink_valid,
  output logic              o_sink_sop,
  output logic              o_sink_eop,
  output logic [DATA_W-1:0] o_sink_real,
  input  logic              i_sink_ready,
  input  logic              i_source_valid,
  input  logic              i_source_sop,
  input  logic              i_source_eop,
  output logic              o_bin_valid,
  output logic [CNT_W-1:0]  o_bin_idx,
  output logic              o_frame_done,
  output logic              o_overflow,
  output logic              o_busy
);

  typedef enum logic [1:0] {IDLE, FILL, WAIT_OUT} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  state_t              state_q;
  logic                full_q;
  logic [DATA_W-1:0]   hold_q;
  logic [CNT_W-1:0]    in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
  logic                overflow_q;
  logic                frame_done_q;

  logic                xfer;
  logic                last_beat;
  logic [CNT_W-1:0]    bin_idx;

  assign xfer      = full_q & i_sink_ready;
  assign last_beat = xfer & (in_cnt_q == LAST_IDX);
  assign bin_idx   = i_source_sop ? '0 : out_cnt_q;

  always_comb begin
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    if (state_q == FILL && xfer) begin
      in_cnt_d = last_beat ? '0 : in_cnt_q + CNT_W'(1);
    end
    // Output beats only advance the bin counter while a frame's results are expected
    if (state_q == WAIT_OUT && i_source_valid) begin
      out_cnt_d = i_source_eop ? '0 : bin_idx + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      full_q       <= 1'b0;
      hold_q       <= '0;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      case (state_q)
        IDLE: begin
          if (i_enable && i_sample_valid) begin
            state_q <= FILL;
            full_q  <= 1'b1;
            hold_q  <= i_sample;
          end
        end
        FILL: begin
          // A sample arriving alongside the final beat belongs to no frame and is discarded
          if (last_beat) begin
            full_q  <= 1'b0;
            state_q <= WAIT_OUT;
          end else if (i_sample_valid && (!full_q || xfer)) begin
            full_q <= 1'b1;
            hold_q <= i_sample;
          end else begin
            if (xfer) begin
              full_q <= 1'b0;
            end
            if (i_sample_valid) begin
              overflow_q <= 1'b1;
            end
          end
        end
        WAIT_OUT: begin
          if (i_source_valid && i_source_eop) begin
            frame_done_q <= 1'b1;
            state_q      <= i_enable ? FILL : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_sink_valid = full_q;
  assign o_sink_sop   = full_q & (in_cnt_q == '0);
  assign o_sink_eop   = full_q & (in_cnt_q == LAST_IDX);
  assign o_sink_real  = hold_q;
  assign o_bin_valid  = i_source_valid;
  assign o_bin_idx    = bin_idx;
  assign o_frame_done = frame_done_q;
  assign o_overflow   = overflow_q;
  assign o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb/tb_fft_frame_ctrl.sv - scoreboard bench for fft_frame_ctrl with a queue-based frame model
module tb_fft_frame_ctrl;

  localparam int FL = 8;
  localparam int DW = 16;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_enable = 1'b0;
  logic          i_sample_valid = 1'b0;
  logic [DW-1:0] i_sample = '0;
  logic          o_sink_valid, o_sink_sop, o_sink_eop;
  logic [DW-1:0] o_sink_real;
  logic          i_sink_ready = 1'b0;
  logic          i_source_valid = 1'b0;
  logic          i_source_sop = 1'b0;
  logic          i_source_eop = 1'b0;
  logic          o_bin_valid;
  logic [CW-1:0] o_bin_idx;
  logic          o_frame_done, o_overflow, o_busy;

  fft_frame_ctrl #(.FRAME_LEN(FL), .DATA_W(DW)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_enable(i_enable),
    .i_sample_valid(i_sample_valid), .i_sample(i_sample),
    .o_sink_valid(o_sink_valid), .o_sink_sop(o_sink_sop), .o_sink_eop(o_sink_eop),
    .o_sink_real(o_sink_real), .i_sink_ready(i_sink_ready),
    .i_source_valid(i_source_valid), .i_source_sop(i_source_sop), .i_source_eop(i_source_eop),
    .o_bin_valid(o_bin_valid), .o_bin_idx(o_bin_idx),
    .o_frame_done(o_frame_done), .o_overflow(o_overflow), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: phase 0 = idle, 1 = collecting samples, 2 = awaiting FFT output
  typedef struct {
    logic [DW-1:0] data;
    bit            sop;
    bit            eop;
  } beat_t;

  beat_t         sink_q[$];
  logic [DW-1:0] held[$];
  int            bin_q[$];
  int            done_q[$];
  int            phase = 0;
  int            m_acc = 0;
  int            m_pos = 0;
  int            m_out = 0;
  bit            m_ovf = 1'b0;
  int            cyc = 0;
  bit            exp_busy, exp_ovf, exp_sv;
  bit            mon_en = 1'b0;

  function automatic void accept(input logic [DW-1:0] v);
    beat_t b;
    b.data = v;
    b.sop  = (m_acc == 0);
    b.eop  = (m_acc == FL - 1);
    held.push_back(v);
    sink_q.push_back(b);
    m_acc++;
  endfunction

  // Evaluated on the falling edge: inputs are those the next rising edge will sample
  always @(negedge clk) begin
    int idx;
    int prev;
    bit xfer;
    bit eop_now;
    cyc++;
    exp_busy = (phase != 0);
    exp_ovf  = m_ovf;
    exp_sv   = (held.size() != 0);
    idx = i_source_sop ? 0 : m_out;
    if (i_source_valid) bin_q.push_back(idx);
    if (i_rst) begin
      phase = 0; m_acc = 0; m_pos = 0; m_out = 0; m_ovf = 1'b0;
      held.delete();
      sink_q.delete();
    end else begin
      prev    = phase;
      xfer    = exp_sv && i_sink_ready;
      eop_now = 1'b0;
      case (phase)
        0: if (i_enable && i_sample_valid) begin
             accept(i_sample);
             phase = 1;
           end
        1: begin
             if (xfer) begin
               void'(held.pop_front());
               m_pos++;
               if (m_pos == FL) begin
                 phase = 2; m_pos = 0; m_acc = 0; eop_now = 1'b1;
               end
             end
             if (i_sample_valid && !eop_now) begin
               if (held.size() == 0) accept(i_sample);
               else m_ovf = 1'b1;
             end
           end
        default: if (i_source_valid && i_source_eop) begin
             done_q.push_back(cyc + 1);
             phase = i_enable ? 1 : 0;
           end
      endcase
      if (prev == 2 && i_source_valid) m_out = i_source_eop ? 0 : (idx + 1) % FL;
    end
  end

  // Monitor: compares DUT outputs against model snapshots and scoreboard queues
  always @(negedge clk) begin
    bit exp_d;
    #1;
    if (mon_en) begin
      chk("busy", o_busy, exp_busy);
      chk("overflow", o_overflow, exp_ovf);
      chk("sink_valid", o_sink_valid, exp_sv);
      if (o_sink_valid && !i_rst) begin
        if (sink_q.size() == 0) begin
          chk("sink_unexpected", 1, 0);
        end else begin
          chk("sink_data", o_sink_real, sink_q[0].data);
          chk("sink_sop", o_sink_sop, sink_q[0].sop);
          chk("sink_eop", o_sink_eop, sink_q[0].eop);
          if (i_sink_ready) void'(sink_q.pop_front());
        end
      end
      chk("bin_valid", o_bin_valid, i_source_valid);
      if (i_source_valid) begin
        if (bin_q.size() == 0) chk("bin_unexpected", 1, 0);
        else chk("bin_idx", o_bin_idx, bin_q.pop_front());
      end
      exp_d = (done_q.size() != 0) && (done_q[0] == cyc);
      chk("frame_done", o_frame_done, exp_d);
      if (exp_d) void'(done_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [DW-1:0] v);
    i_sample       = v;
    i_sample_valid = 1'b1;
    tick();
    i_sample_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    i_rst = 1'b1;
    repeat (n) tick();
    i_rst = 1'b0;
  endtask

  task automatic fill_rest(input bit rnd, input string name);
    int n = 0;
    while (phase != 2 && n < 400) begin
      i_sample_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      i_sample       = DW'($urandom);
      if (rnd) i_sink_ready = ($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    i_sample_valid = 1'b0;
    i_sink_ready   = 1'b1;
    if (phase != 2) chk({name, "_fill_timeout"}, phase, 2);
  endtask

  task automatic src_frame(input bit gaps);
    for (int k = 0; k < FL; k++) begin
      if (gaps) begin
        i_source_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          i_sample_valid = 1'($urandom_range(0, 1));
          i_sample       = DW'($urandom);
          tick();
        end
      end
      i_source_valid = 1'b1;
      i_source_sop   = (k == 0);
      i_source_eop   = (k == FL - 1);
      tick();
    end
    i_source_valid = 1'b0;
    i_source_sop   = 1'b0;
    i_source_eop   = 1'b0;
    i_sample_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    do_reset(3);
    mon_en = 1'b1;
    tick();
    chk("rst_sink_valid", o_sink_valid, 0);
    chk("rst_sink_sop", o_sink_sop, 0);
    chk("rst_sink_eop", o_sink_eop, 0);
    chk("rst_sink_real", o_sink_real, 0);
    chk("rst_frame_done", o_frame_done, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_overflow", o_overflow, 0);

    // Samples 1..8 spaced 4 cycles apart with the FFT always ready
    i_enable = 1'b1;
    i_sink_ready = 1'b1;
    for (int v = 1; v <= FL; v++) begin
      sample(DW'(v));
      repeat (3) tick();
    end
    chk("wait_busy", o_busy, 1);
    chk("wait_sink_valid", o_sink_valid, 0);
    src_frame(1'b0);
    chk("done_pulse", o_frame_done, 1);
    chk("done_busy_fill", o_busy, 1);
    tick();
    chk("done_one_cycle", o_frame_done, 0);

    // Backpressure: second sample dropped, overflow latches
    do_reset(1);
    i_enable = 1'b1;
    i_sink_ready = 1'b0;
    sample(DW'(5));
    tick();
    sample(DW'(6));
    repeat (8) tick();
    chk("ovf_hold_real", o_sink_real, 5);
    chk("ovf_set", o_overflow, 1);
    i_sink_ready = 1'b1;
    tick();
    fill_rest(1'b0, "ovf");
    src_frame(1'b1);
    tick();
    chk("ovf_sticky", o_overflow, 1);
    do_reset(1);
    chk("ovf_cleared", o_overflow, 0);

    // Transfer and reload in the same cycle
    i_enable = 1'b1;
    i_sink_ready = 1'b0;
    sample(DW'(5));
    tick();
    i_sink_ready = 1'b1;
    sample(DW'(6));
    chk("reload_real", o_sink_real, 6);
    chk("reload_valid", o_sink_valid, 1);
    chk("reload_no_ovf", o_overflow, 0);
    fill_rest(1'b0, "reload");
    src_frame(1'b1);
    tick();

    // Enable drops mid-frame: frame completes, then idle
    for (int v = 0; v < 3; v++) sample(DW'(100 + v));
    i_enable = 1'b0;
    fill_rest(1'b0, "disable");
    chk("disable_busy_wait", o_busy, 1);
    src_frame(1'b1);
    tick();
    chk("disable_idle", o_busy, 0);
    sample(DW'(9));
    chk("idle_ignores_sample", o_sink_valid, 0);

    // Stray output beat while idle
    i_source_valid = 1'b1;
    i_source_sop = 1'b1;
    i_source_eop = 1'b1;
    tick();
    i_source_valid = 1'b0;
    i_source_sop = 1'b0;
    i_source_eop = 1'b0;
    tick();
    chk("stray_no_done", o_frame_done, 0);
    chk("stray_busy", o_busy, 0);

    // Reset after five sink beats abandons the frame
    i_enable = 1'b1;
    i_sink_ready = 1'b1;
    for (int v = 0; v < 5; v++) sample(DW'(200 + v));
    tick();
    do_reset(1);
    chk("midrst_valid", o_sink_valid, 0);
    chk("midrst_real", o_sink_real, 0);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_sop", o_sink_sop, 0);
    sample(DW'(16'h0077));
    chk("midrst_new_sop", o_sink_sop, 1);
    fill_rest(1'b0, "midrst");
    src_frame(1'b1);
    tick();

    // Randomized frames with random gaps, backpressure and enable
    do_reset(1);
    for (int f = 0; f < 8; f++) begin
      i_enable = 1'b1;
      fill_rest(1'b1, "rand");
      i_enable = 1'($urandom_range(0, 1));
      src_frame(1'b1);
      repeat ($urandom_range(1, 3)) tick();
    end

    repeat (3) tick();
    chk("sink_q_drained", sink_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
